// File: rtl/cook_countdown.sv
// rtl/cook_countdown.sv - egg-timer mm:ss countdown core with SET/RUN/PAUSE/DONE FSM.
// Optional build macro COUNTDOWN_BLINK_ALARM_EN makes the DONE alarm LED blink on ticks.
module cook_countdown #(
  parameter int PRESET_MIN = 4,
  parameter int PRESET_SEC = 0,
  parameter int MAX_MIN    = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick_1hz,
  input  logic       minutes,
  input  logic       seconds,
  input  logic       cook_time,
  input  logic       start,
  output logic [5:0] q_minutes,
  output logic [5:0] q_seconds,
  output logic [1:0] state,
  output logic [1:0] LED,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_SET   = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [5:0] MAX_MIN_V    = 6'(MAX_MIN);
  localparam logic [5:0] PRESET_MIN_V = 6'(PRESET_MIN);
  localparam logic [5:0] PRESET_SEC_V = 6'(PRESET_SEC);

  // Bit order in the button vectors: {start, cook_time, seconds, minutes}
  logic [3:0] btn_q, btn_prev_q, btn_edge;
  logic       min_e, sec_e, cook_e, start_e;

  state_t     state_q, state_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [1:0] led_q, led_d;
  logic       done_q, alarm_d;

  assign btn_edge = btn_q & ~btn_prev_q;
  assign min_e    = btn_edge[0];
  assign sec_e    = btn_edge[1];
  assign cook_e   = btn_edge[2];
  assign start_e  = btn_edge[3];

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    alarm_d = led_q[1];
    if (enable) begin
      case (state_q)
        ST_SET: begin
          if (cook_e) begin
            min_d = PRESET_MIN_V;
            sec_d = PRESET_SEC_V;
          end else begin
            if (min_e) min_d = (min_q == MAX_MIN_V) ? 6'd0 : min_q + 6'd1;
            if (sec_e) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          end
          if (start_e && (min_q != 6'd0 || sec_q != 6'd0)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick_1hz) begin
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else if (min_q != 6'd0) begin
              sec_d = 6'd59;
              min_d = min_q - 6'd1;
            end
          end
          // Reaching zero on this tick beats a coincident pause request
          if (tick_1hz && min_d == 6'd0 && sec_d == 6'd0) begin
            state_d = ST_DONE;
            alarm_d = 1'b1;
          end else if (start_e) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (cook_e) begin
            min_d   = PRESET_MIN_V;
            sec_d   = PRESET_SEC_V;
            state_d = ST_SET;
          end else if (start_e) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          if (|btn_edge) begin
            state_d = ST_SET;
          end else begin
`ifdef COUNTDOWN_BLINK_ALARM_EN
            if (tick_1hz) alarm_d = ~led_q[1];
`endif
          end
        end
      endcase
    end
    led_d = {(state_d == ST_DONE) ? alarm_d : 1'b0, state_d == ST_RUN};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q      <= 4'b0;
      btn_prev_q <= 4'b0;
      state_q    <= ST_SET;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      led_q      <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      // Edge history runs regardless of enable so held buttons are not re-seen later
      btn_q      <= {start, cook_time, seconds, minutes};
      btn_prev_q <= btn_q;
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      led_q      <= led_d;
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign q_minutes = min_q;
  assign q_seconds = sec_q;
  assign state     = state_q;
  assign LED       = led_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cook_countdown.sv
// tb/tb_cook_countdown.sv - directed self-checking bench for cook_countdown.
module tb_cook_countdown;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       minutes = 1'b0;
  logic       seconds = 1'b0;
  logic       cook_time = 1'b0;
  logic       start = 1'b0;
  logic [5:0] q_minutes, q_seconds;
  logic [1:0] state, LED;
  logic       done;

  int tests = 0;
  int fails = 0;

  cook_countdown dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_1hz(tick_1hz),
    .minutes(minutes), .seconds(seconds), .cook_time(cook_time), .start(start),
    .q_minutes(q_minutes), .q_seconds(q_seconds), .state(state), .LED(LED), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int m, input int s, input int st,
                           input int led, input int dn);
    check({tag, ".min"}, 16'(q_minutes), 16'(m));
    check({tag, ".sec"}, 16'(q_seconds), 16'(s));
    check({tag, ".state"}, 16'(state), 16'(st));
    check({tag, ".led"}, 16'(LED), 16'(led));
    check({tag, ".done"}, 16'(done), 16'(dn));
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // mask = {start, cook_time, seconds, minutes}; result is visible on return
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    {start, cook_time, seconds, minutes} = mask;
    @(negedge clk);
    {start, cook_time, seconds, minutes} = 4'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0);

    repeat (3) press(4'b0001);
    repeat (5) press(4'b0010);
    check_all("set_3_5", 3, 5, 0, 0, 0);

    repeat (54) press(4'b0010);
    check("sec_at_59", 16'(q_seconds), 16'd59);
    press(4'b0010);
    check("sec_wrap", 16'(q_seconds), 16'd0);
    repeat (56) press(4'b0001);
    check("min_at_max", 16'(q_minutes), 16'd59);
    press(4'b0001);
    check("min_wrap", 16'(q_minutes), 16'd0);
    press(4'b0001);
    press(4'b0010);
    press(4'b0011);
    check_all("both_edges", 2, 2, 0, 0, 0);

    do_reset();
    press(4'b1000);
    check("start_at_zero", 16'(state), 16'd0);
    press(4'b0100);
    check_all("preset", 4, 0, 0, 0, 0);
    press(4'b1000);
    check_all("run_entry", 4, 0, 1, 1, 0);
    tick();
    tick();
    check_all("run_2ticks", 3, 58, 1, 1, 0);

    do_reset();
    press(4'b0001);
    press(4'b1000);
    tick();
    check_all("borrow", 0, 59, 1, 1, 0);
    repeat (58) tick();
    check_all("at_0001", 0, 1, 1, 1, 0);
    tick();
    check_all("done", 0, 0, 3, 2, 1);
    tick();
`ifdef COUNTDOWN_BLINK_ALARM_EN
    check("alarm_after_tick", 16'(LED), 16'd0);
`else
    check("alarm_after_tick", 16'(LED), 16'd2);
`endif
    press(4'b0010);
    check_all("done_exit", 0, 0, 0, 0, 0);

    do_reset();
    repeat (10) press(4'b0010);
    press(4'b1000);
    press(4'b1000);
    check_all("pause", 0, 10, 2, 0, 0);
    repeat (3) tick();
    check_all("pause_ticks", 0, 10, 2, 0, 0);
    press(4'b1000);
    tick();
    check_all("resume", 0, 9, 1, 1, 0);
    repeat (8) tick();
    check("at_one", 16'(q_seconds), 16'd1);
    // start edge lands on the same clk as the final tick
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; tick_1hz = 1'b1; end
    @(negedge clk) tick_1hz = 1'b0;
    check_all("done_beats_pause", 0, 0, 3, 2, 1);

    do_reset();
    press(4'b0010);
    press(4'b1000);
    press(4'b1000);
    press(4'b0100);
    check_all("pause_abort", 4, 0, 0, 0, 0);

    do_reset();
    repeat (5) press(4'b0010);
    press(4'b1000);
    @(negedge clk) enable = 1'b0;
    repeat (4) tick();
    press(4'b1000);
    @(negedge clk) enable = 1'b1;
    check_all("enable_low", 0, 5, 1, 1, 0);
    tick();
    check("enable_back", 16'(q_seconds), 16'd4);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check_all("mid_run_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cook_countdown.md
Name: cook_countdown

Overview:
- Timekeeping core of the egg timer; sits directly upstream of the binary-to-BCD converters and the 7-segment path.
- Takes debounced minute/second buttons, a cook-time preset button, a start/pause button and a 1 Hz tick enable.
- Holds the mm:ss value as two 6-bit binary registers and runs the SET / RUN / PAUSE / DONE state machine.
- Replaces the gated-clock counter pair with a single-clock design: one clock, all events are enables.

Parameters:
- PRESET_MIN, 4, minutes loaded by cook_time (0..MAX_MIN)
- PRESET_SEC, 0, seconds loaded by cook_time (0..59)
- MAX_MIN, 59, highest settable minute value; minute increment wraps to 0 above it

Ports:
- clk  input  1  system clock (5 MHz domain)
- reset  input  1  synchronous, active-high reset
- enable  input  1  global enable; low freezes state, value and LEDs
- tick_1hz  input  1  one-clk-wide pulse once per second, synchronous to clk
- minutes  input  1  debounced minute button, level
- seconds  input  1  debounced second button, level
- cook_time  input  1  preset button, level
- start  input  1  start/pause button, level
- q_minutes  output  6  current minutes, binary 0..MAX_MIN
- q_seconds  output  6  current seconds, binary 0..59
- state  output  2  00 SET, 01 RUN, 10 PAUSE, 11 DONE
- LED  output  2  LED[0] running indicator, LED[1] alarm
- done  output  1  high while state is DONE

Behaviour:
- Reset (sync, active-high): state=SET, q_minutes=0, q_seconds=0, LED=00, done=0, and all edge-detect history registers cleared to 0.
- Edge detection:
  - Each level button is registered once.
  - A rising-edge event is asserted for exactly one clk when current=1 and previous=0.
  - History registers update every clk, regardless of enable.
- enable=0: no state change, no value change, no LED toggle. Edges and ticks arriving during this time are dropped, not queued.
- SET:
  - minutes edge: q_minutes <= (q_minutes==MAX_MIN) ? 0 : q_minutes+1.
  - seconds edge: q_seconds <= (q_seconds==59) ? 0 : q_seconds+1.
  - Minutes and seconds edges in the same clk both apply.
  - cook_time edge: load PRESET_MIN:PRESET_SEC. This load has priority over minutes/seconds edges in the same clk.
  - start edge with value != 00:00: go to RUN on the next clk. With value == 00:00: stay in SET.
  - tick_1hz is ignored.
- RUN:
  - On tick_1hz: if q_seconds>0, decrement q_seconds. Otherwise (q_minutes>0) set q_seconds=59 and decrement q_minutes.
  - If the decremented value is 00:00, go to DONE in the same update (registered together with the value).
  - start edge: go to PAUSE. If start edge and tick occur in the same clk, the tick is applied first, then PAUSE. If that tick reached 00:00, DONE wins.
  - minutes, seconds and cook_time edges are ignored.
- PAUSE:
  - Value is held and ticks are ignored.
  - start edge: go to RUN.
  - cook_time edge: reload the preset and go to SET (abort).
  - minutes/seconds edges are ignored.
- DONE:
  - Value is held at 00:00 and done=1.
  - Any rising edge on minutes, seconds, cook_time or start: go to SET, clear done and LED[1]. Value stays 00:00.
- LED[0] = 1 iff state==RUN (registered).
- LED[1]: see Optional Feature. Forced to 0 outside DONE.
- Latency:
  - Button edge to output change: 2 clk (1 clk for the sync register, 1 clk for the update).
  - tick to value change: 1 clk.
- Values are never out of range. MAX_MIN must be ≤ 63; violating it is a configuration error and is not checked in hardware.

Optional Feature:
- Macro: COUNTDOWN_BLINK_ALARM_EN.
- Defined: on entering DONE, LED[1]=1. It then toggles on every tick_1hz (while enable=1) for as long as the state is DONE.
- Not defined: LED[1] is solid 1 throughout DONE.
- Both builds: LED[1]=0 in all other states and after reset.

Test Plan:
- Reset, then 3 minutes edges and 5 seconds edges -> q_minutes=3, q_seconds=5, state=SET, LED=00.
- q_seconds=59, seconds edge -> q_seconds=0. q_minutes=MAX_MIN(59), minutes edge -> q_minutes=0. Minutes and seconds edges in the same clk from 01:01 -> 02:02.
- Value 00:00, start edge -> state stays SET. cook_time edge -> 04:00. Start edge, then 2 ticks -> 03:58 with LED[0]=1.
- Value 01:00 in RUN, 1 tick -> 00:59. 59 more ticks -> 00:00, state=DONE, done=1, LED[0]=0, LED[1]=1. With the macro defined, next tick -> LED[1]=0. Without it, LED[1] stays 1.
- RUN at 00:10, start edge -> PAUSE. 3 ticks -> still 00:10. Start edge, then 1 tick -> 00:09. Start edge coincident with tick at 00:01 -> DONE, not PAUSE.
- enable=0 during RUN at 00:05, 4 ticks plus a start edge -> value 00:05, state RUN. Synchronous reset asserted mid-RUN -> next clk 00:00, SET, LED=00, done=0.
